// File: rtl/step_pkg.sv
// Shared types and default thresholds for the step tracker.
// Holds the activity FSM encoding and parameter defaults.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_HIGH  = 2'd2
  } act_state_t;

  localparam int unsigned STEP_MAX_D   = 9999;
  localparam int unsigned SPHM_D       = 1024;
  localparam int unsigned FAST_D       = 32;
  localparam int unsigned HIGH_D       = 64;
  localparam int unsigned HIGH_RUN_D   = 60;

endpackage

// File: rtl/edge_det.sv
// Single-register rising-edge detector.
// Ports: clk, rst_n, i_d (level in), o_rise (i_d high, last sample low).
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/step_tracker.sv
// Pedometer statistics: step count, distance, fast seconds, high activity.
// Ports: clk, rst_n, clk1hz, start, pulse in; step/dist/activity stats out.
module step_tracker
  import step_pkg::*;
#(
  parameter int unsigned STEP_MAX            = STEP_MAX_D,
  parameter int unsigned STEPS_PER_HALF_MILE = SPHM_D,
  parameter int unsigned FAST_THRESH         = FAST_D,
  parameter int unsigned HIGH_THRESH         = HIGH_D,
  parameter int unsigned HIGH_RUN            = HIGH_RUN_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk1hz,
  input  logic        start,
  input  logic        pulse,
  output logic [13:0] step_count,
  output logic        step_sat,
  output logic [4:0]  dist_half,
  output logic [3:0]  fast_secs,
  output logic [15:0] high_secs,
  output logic        high_active
);

  localparam int MW =
    (STEPS_PER_HALF_MILE > 1) ? $clog2(STEPS_PER_HALF_MILE) : 1;
  localparam logic [13:0]   L_MAX  = 14'(STEP_MAX);
  localparam logic [MW-1:0] L_WRAP = MW'(STEPS_PER_HALF_MILE - 1);
  localparam logic [7:0]    L_FAST = 8'(FAST_THRESH);
  localparam logic [7:0]    L_HIGH = 8'(HIGH_THRESH);
  localparam logic [15:0]   L_RUN  = 16'(HIGH_RUN);

  logic w_p_rise;
  logic w_c_rise;
  logic w_start_rise;
  logic w_step_evt;
  logic w_tick;
  logic w_ev_tick;
  logic w_qual;
  logic r_start_q;
  logic r_step;
  logic r_tick;

  logic [13:0]   r_count;
  logic          r_sat;
  logic [MW-1:0] r_mod;
  logic [4:0]    r_dist;
  logic [7:0]    r_sec_steps;
  logic [3:0]    r_sec_num;
  logic [3:0]    r_fast;
  logic [15:0]   r_high;
  logic [15:0]   r_run;
  logic [15:0]   w_run_inc;
  logic [16:0]   w_high_add;

  act_state_t r_state;
  act_state_t w_state_nxt;

  edge_det u_pulse_ed (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (pulse),
    .o_rise (w_p_rise)
  );

  edge_det u_sec_ed (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (clk1hz),
    .o_rise (w_c_rise)
  );

  assign w_start_rise = start & ~r_start_q;
  assign w_step_evt   = w_p_rise & start;
  assign w_tick       = w_c_rise & start;

  // Events are registered once; counters act on the registered copy.
  // An edge landing on the start-rise cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_step    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_step    <= w_step_evt & ~w_start_rise;
      r_tick    <= w_tick & ~w_start_rise;
    end
  end

  // Statistics datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_sat       <= 1'b0;
      r_mod       <= '0;
      r_dist      <= '0;
      r_sec_steps <= '0;
      r_sec_num   <= '0;
      r_fast      <= '0;
    end else if (w_start_rise) begin
      r_count     <= '0;
      r_sat       <= 1'b0;
      r_mod       <= '0;
      r_dist      <= '0;
      r_sec_steps <= '0;
      r_sec_num   <= '0;
      r_fast      <= '0;
    end else if (start) begin
      if (r_step) begin
        if (r_count != L_MAX) begin
          r_count <= r_count + 14'd1;
          if (r_count + 14'd1 == L_MAX) r_sat <= 1'b1;
        end
        if (r_mod == L_WRAP) begin
          r_mod <= '0;
          if (r_dist != 5'd31) r_dist <= r_dist + 5'd1;
        end else begin
          r_mod <= r_mod + MW'(1);
        end
      end
      // A step coinciding with the tick opens the new second.
      if (r_tick) begin
        r_sec_steps <= {7'd0, r_step};
        if (r_sec_num != 4'd15) r_sec_num <= r_sec_num + 4'd1;
        if (r_sec_num <= 4'd8 && r_sec_steps > L_FAST &&
            r_fast != 4'd15)
          r_fast <= r_fast + 4'd1;
      end else if (r_step && r_sec_steps != 8'd255) begin
        r_sec_steps <= r_sec_steps + 8'd1;
      end
    end
  end

  assign w_ev_tick  = start & ~w_start_rise & r_tick;
  assign w_qual     = (r_sec_steps >= L_HIGH);
  assign w_run_inc  = r_run + 16'd1;
  assign w_high_add = {1'b0, r_high} + {1'b0, L_RUN};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_state <= ST_IDLE;
    else if (w_start_rise) r_state <= ST_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_ev_tick) begin
      unique case (r_state)
        ST_IDLE:  if (w_qual) w_state_nxt = ST_BUILD;
        ST_BUILD: begin
          if (!w_qual)              w_state_nxt = ST_IDLE;
          else if (w_run_inc == L_RUN) w_state_nxt = ST_HIGH;
        end
        ST_HIGH:  if (!w_qual) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    high_active = (r_state == ST_HIGH);
  end

  // Run length and high-activity seconds follow the FSM transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= '0;
      r_high <= '0;
    end else if (w_start_rise) begin
      r_run  <= '0;
      r_high <= '0;
    end else if (w_ev_tick) begin
      unique case (r_state)
        ST_IDLE: if (w_qual) r_run <= 16'd1;
        ST_BUILD: begin
          if (!w_qual) begin
            r_run <= '0;
          end else begin
            r_run <= w_run_inc;
            if (w_run_inc == L_RUN)
              r_high <= w_high_add[16] ? 16'hFFFF : w_high_add[15:0];
          end
        end
        ST_HIGH: begin
          if (!w_qual)              r_run  <= '0;
          else if (r_high != 16'hFFFF) r_high <= r_high + 16'd1;
        end
        default: r_run <= '0;
      endcase
    end
  end

  assign step_count = r_count;
  assign step_sat   = r_sat;
  assign dist_half  = r_dist;
  assign fast_secs  = r_fast;
  assign high_secs  = r_high;

endmodule

// File: tb/tb_step_tracker.sv
// Self-checking bench for step_tracker.
// Expected values are queued at stimulus time and popped at check time.
module tb_step_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk1hz;
  logic        start;
  logic        pulse;
  logic [13:0] step_count;
  logic        step_sat;
  logic [4:0]  dist_half;
  logic [3:0]  fast_secs;
  logic [15:0] high_secs;
  logic        high_active;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int e;

  step_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk1hz      (clk1hz),
    .start       (start),
    .pulse       (pulse),
    .step_count  (step_count),
    .step_sat    (step_sat),
    .dist_half   (dist_half),
    .fast_secs   (fast_secs),
    .high_secs   (high_secs),
    .high_active (high_active)
  );

  always #5 clk = ~clk;

  task automatic do_step();
    @(negedge clk) pulse = 1'b1;
    @(negedge clk) pulse = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk) clk1hz = 1'b1;
    @(negedge clk) clk1hz = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; pulse = 1'b0; clk1hz = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) start = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pulse = 1'b0; clk1hz = 1'b0;
    repeat (6) exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL rst_count got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (step_sat !== 1'(e)) $display("FAIL rst_sat got=%0d exp=%0d", step_sat, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (dist_half !== 5'(e)) $display("FAIL rst_dist got=%0d exp=%0d", dist_half, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL rst_fast got=%0d exp=%0d", fast_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (high_secs !== 16'(e)) $display("FAIL rst_high got=%0d exp=%0d", high_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (high_active !== 1'(e)) $display("FAIL rst_active got=%0d exp=%0d", high_active, e); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) start = 1'b1;
    settle();
  endtask

  task automatic test_steps();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk) pulse = 1'b1;
      exp_q.push_back(i);
      @(posedge clk) #1;
      n_total++;
      if (step_count !== 14'(i - 1))
        $display("FAIL step_early%0d got=%0d exp=%0d", i, step_count, i - 1);
      else n_pass++;
      @(negedge clk) pulse = 1'b0;
      @(posedge clk) #1;
      e = exp_q.pop_front(); n_total++;
      if (step_count !== 14'(e))
        $display("FAIL step_late%0d got=%0d exp=%0d", i, step_count, e);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (9216) do_step();
    exp_q.push_back(9216); exp_q.push_back(9); exp_q.push_back(0);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL sat_cnt9216 got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (dist_half !== 5'(e)) $display("FAIL sat_dist9216 got=%0d exp=%0d", dist_half, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (step_sat !== 1'(e)) $display("FAIL sat_flag9216 got=%0d exp=%0d", step_sat, e); else n_pass++;
    repeat (784) do_step();
    exp_q.push_back(9999); exp_q.push_back(1); exp_q.push_back(9);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL sat_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (step_sat !== 1'(e)) $display("FAIL sat_flag got=%0d exp=%0d", step_sat, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (dist_half !== 5'(e)) $display("FAIL sat_dist got=%0d exp=%0d", dist_half, e); else n_pass++;
  endtask

  task automatic test_fast();
    do_reset();
    for (int s = 0; s < 12; s++) begin
      repeat (40) do_step();
      do_tick();
    end
    exp_q.push_back(9); exp_q.push_back(480);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL fast_secs got=%0d exp=%0d", fast_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL fast_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
  endtask

  task automatic test_high();
    do_reset();
    for (int s = 0; s < 59; s++) begin
      repeat (64) do_step();
      do_tick();
    end
    repeat (10) do_step();
    do_tick();
    exp_q.push_back(0); exp_q.push_back(0);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (high_secs !== 16'(e)) $display("FAIL high_broken got=%0d exp=%0d", high_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (high_active !== 1'(e)) $display("FAIL act_broken got=%0d exp=%0d", high_active, e); else n_pass++;
    for (int s = 0; s < 59; s++) begin
      repeat (64) do_step();
      do_tick();
    end
    exp_q.push_back(0);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (high_active !== 1'(e)) $display("FAIL act_59 got=%0d exp=%0d", high_active, e); else n_pass++;
    repeat (64) do_step();
    do_tick();
    exp_q.push_back(60); exp_q.push_back(1);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (high_secs !== 16'(e)) $display("FAIL high_60 got=%0d exp=%0d", high_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (high_active !== 1'(e)) $display("FAIL act_60 got=%0d exp=%0d", high_active, e); else n_pass++;
    repeat (64) do_step();
    do_tick();
    exp_q.push_back(61); exp_q.push_back(1);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (high_secs !== 16'(e)) $display("FAIL high_61 got=%0d exp=%0d", high_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (high_active !== 1'(e)) $display("FAIL act_61 got=%0d exp=%0d", high_active, e); else n_pass++;
  endtask

  task automatic test_coincide();
    do_reset();
    repeat (32) do_step();
    @(negedge clk) begin pulse = 1'b1; clk1hz = 1'b1; end
    @(negedge clk) begin pulse = 1'b0; clk1hz = 1'b0; end
    exp_q.push_back(0); exp_q.push_back(33);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL coin_old got=%0d exp=%0d", fast_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL coin_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
    repeat (32) do_step();
    do_tick();
    exp_q.push_back(1);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL coin_new got=%0d exp=%0d", fast_secs, e); else n_pass++;
  endtask

  task automatic test_start_reset();
    do_reset();
    repeat (40) do_step();
    do_tick();
    exp_q.push_back(40); exp_q.push_back(1);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL run_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL run_fast got=%0d exp=%0d", fast_secs, e); else n_pass++;
    @(negedge clk) start = 1'b0;
    repeat (40) do_step();
    do_tick();
    do_tick();
    exp_q.push_back(40); exp_q.push_back(1);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL frz_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL frz_fast got=%0d exp=%0d", fast_secs, e); else n_pass++;
    @(negedge clk) begin start = 1'b1; pulse = 1'b1; end
    @(negedge clk) pulse = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL restart_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (fast_secs !== 4'(e)) $display("FAIL restart_fast got=%0d exp=%0d", fast_secs, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (dist_half !== 5'(e)) $display("FAIL restart_dist got=%0d exp=%0d", dist_half, e); else n_pass++;
    repeat (5) do_step();
    exp_q.push_back(5);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL pre_rst got=%0d exp=%0d", step_count, e); else n_pass++;
    @(posedge clk) #2 rst_n = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL async_cnt got=%0d exp=%0d", step_count, e); else n_pass++;
    e = exp_q.pop_front(); n_total++;
    if (high_active !== 1'(e)) $display("FAIL async_act got=%0d exp=%0d", high_active, e); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) do_step();
    exp_q.push_back(3);
    settle();
    e = exp_q.pop_front(); n_total++;
    if (step_count !== 14'(e)) $display("FAIL post_rst got=%0d exp=%0d", step_count, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_saturation();
    test_fast();
    test_high();
    test_coincide();
    test_start_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/step_tracker.md
STEP_TRACKER -- requirements
Module: step_tracker

Interface
REQ-001 SHALL have parameter STEP_MAX, default 9999, the saturation value of the step count.
REQ-002 SHALL have parameter STEPS_PER_HALF_MILE, default 1024, the steps per distance increment.
REQ-003 SHALL have parameter FAST_THRESH, default 32, the steps/second a second must exceed to count as fast.
REQ-004 SHALL have parameter HIGH_THRESH, default 64, the minimum steps/second for high activity.
REQ-005 SHALL have parameter HIGH_RUN, default 60, the consecutive qualifying seconds needed to enter high activity.
REQ-006 SHALL have port clk, input, 1 bit, the single system clock.
REQ-007 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-008 SHALL have port clk1hz, input, 1 bit, the 1 Hz level, synchronous to clk.
REQ-009 SHALL have port start, input, 1 bit, the activity enable shared with the pulse generator.
REQ-010 SHALL have port pulse, input, 1 bit, the step waveform from the pulse generator; one rising edge is one step.
REQ-011 SHALL have port step_count, output, 14 bits, the total steps, saturating.
REQ-012 SHALL have port step_sat, output, 1 bit, a sticky flag that step_count has saturated.
REQ-013 SHALL have port dist_half, output, 5 bits, the distance in half-mile units, saturating at 31.
REQ-014 SHALL have port fast_secs, output, 4 bits, the number of seconds among the first 9 with more than FAST_THRESH steps.
REQ-015 SHALL have port high_secs, output, 16 bits, the accumulated high-activity seconds, saturating at 65535.
REQ-016 SHALL have port high_active, output, 1 bit, asserted while the FSM is in HIGH.

Function
REQ-017 SHALL register pulse and clk1hz once and define step_evt = pulse & ~pulse_q & start, and tick = clk1hz & ~clk1hz_q & start.
REQ-018 SHALL update all step-driven outputs on the clk edge following the edge that registers step_evt (1-cycle latency).
REQ-019 SHALL increment step_count on step_evt until it equals STEP_MAX, then hold it and set step_sat.
REQ-020 SHALL count steps modulo STEPS_PER_HALF_MILE, independent of step_count saturation, and increment dist_half on each wrap to 0.
REQ-021 SHALL keep an 8-bit per-second step counter, sec_steps, saturating at 255, and clear it on tick.
REQ-022 SHALL, when tick and step_evt occur in the same cycle, evaluate the closing second without that step and load sec_steps to 1.
REQ-023 SHALL keep a 4-bit completed-second index, sec_num, that increments on tick and saturates at 15.
REQ-024 SHALL increment fast_secs on a tick that closes second 1..9 (sec_num 0..8 before the increment) when sec_steps > FAST_THRESH.
REQ-025 SHALL implement a high-activity FSM with states IDLE, BUILD and HIGH, evaluated only on tick; a qualifying second has sec_steps >= HIGH_THRESH.
REQ-026 FSM IDLE SHALL go to BUILD with run_len = 1 on a qualifying second, and otherwise stay in IDLE.
REQ-027 FSM BUILD SHALL increment run_len on a qualifying second; when run_len reaches HIGH_RUN it SHALL add HIGH_RUN to high_secs (saturating) and go to HIGH.
REQ-028 FSM BUILD SHALL go to IDLE and clear run_len on a non-qualifying second.
REQ-029 FSM HIGH SHALL add 1 to high_secs (saturating) on a qualifying second.
REQ-030 FSM HIGH SHALL go to IDLE and clear run_len on a non-qualifying second.
REQ-031 SHALL, while start is low, freeze all counters, outputs and FSM state and ignore pulse and clk1hz edges.
REQ-032 SHALL, on the rising edge of start, clear all statistics and the FSM to IDLE in that cycle; a step_evt in the same cycle is dropped.

Reset
REQ-033 SHALL, on rst_n low, asynchronously force step_count=0, step_sat=0, dist_half=0, fast_secs=0, high_secs=0, high_active=0, FSM=IDLE, and clear all internal counters and edge registers.
REQ-034 SHALL resume operation on the first clk edge after rst_n deasserts; a reset mid-activity SHALL discard any partial second.

Structure
REQ-035 SHALL place the FSM state encoding and the default thresholds in shared package step_pkg.
REQ-036 SHALL instantiate one sub-module, edge_det (register plus rising-edge pulse), once for pulse and once for clk1hz.

Verification
REQ-037 SHALL cover: 10 pulse edges with start=1 -> step_count=10, each update 1 cycle after its edge.
REQ-038 SHALL cover: 10000 steps -> step_count=9999, step_sat=1, dist_half=9 (not 9 at 9999 without the wrap: check 9 after step 9216).
REQ-039 SHALL cover: 40 steps in each of seconds 1-12 -> fast_secs=9.
REQ-040 SHALL cover: 64 steps/s for 59 s, then 10 steps, then 64 steps/s for 61 s -> high_secs=61 and high_active=1 at the end.
REQ-041 SHALL cover: tick and step_evt in the same cycle -> the step counts in the new second (sec_steps=1).
REQ-042 SHALL cover: start dropped mid-run, pulses applied, start raised -> outputs frozen while low and all 0 after the rising edge; rst_n pulsed mid-second -> all 0 asynchronously.
